muldiv_sequencer: RTL and testbench

- Iterative multi-cycle controller for the RV32M multiply/divide operations; it sits beside the ALU in the execute stage.
- Accepts an M-extension request (funct3 plus two operands) and sequences one shift-add or restoring-divide step per clock.
- Applies sign correction and handles RISC-V divide special cases.
- Holds the pipeline via busy until the result is ready.

---
 rtl/muldiv_sequencer_if.sv | 15 +
 rtl/muldiv_sequencer.sv | 135 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and the M-extension sequencer.
// The pipeline drives the request side as master; the sequencer answers as slave.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
   logic             start;
   logic [2:0]       funct3;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             kill;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (output start, funct3, op_a, op_b, kill, input busy, done, result);
   modport slave  (input start, funct3, op_a, op_b, kill, output busy, done, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-divide step per clock,
// sign fix-up at the end, divide special cases resolved without iterating.
//   state  | meaning
//   S_IDLE | waiting for start
//   S_CALC | WIDTH iterations on operand magnitudes
//   S_FIX  | sign correction, result register load
//   S_DONE | done pulse; may accept a new start
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input logic               clk,
   input logic               rst_n,
   muldiv_sequencer_if.slave bus
);
   localparam int              CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2:0]         f3_q, f3_d;
   logic               sa_q, sa_d, sb_q, sb_d;
   logic [2*WIDTH-1:0] a_q, a_d, acc_q, acc_d;
   logic [WIDTH-1:0]   b_q, b_d, res_q, res_d;

   logic               a_signed, b_signed, div_zero, div_ovf, accept;
   logic [WIDTH-1:0]   a_mag, b_mag, special_res;

   always_comb begin
      a_signed = bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
      b_signed = bus.funct3 inside {3'b001, 3'b100, 3'b110};
      a_mag    = (a_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
      b_mag    = (b_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
      div_zero = bus.funct3[2] && (bus.op_b == '0);
      div_ovf  = bus.funct3[2] && !bus.funct3[0] && (bus.op_a == MIN_NEG) && (bus.op_b == '1);
      if (div_zero) special_res = bus.funct3[1] ? bus.op_a : '1;
      else          special_res = bus.funct3[1] ? '0 : bus.op_a;
      accept   = bus.start && !bus.kill && (state_q == S_IDLE || state_q == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) state_d = (div_zero || div_ovf) ? S_DONE : S_CALC;
            else        state_d = S_IDLE;
         end
         S_CALC:  if (cnt_q == LAST) state_d = S_FIX;
         S_FIX:   state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
      if (bus.kill) state_d = S_IDLE;
   end

   always_comb begin
      bus.busy   = (state_q == S_CALC) || (state_q == S_FIX);
      bus.done   = (state_q == S_DONE);
      bus.result = res_q;
   end

   // Divide reuses a_q[WIDTH-1:0] as the dividend/quotient shifter and acc_q as remainder.
   logic [WIDTH:0]     rem_sh, rem_diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem, fix_res;

   always_comb begin
      f3_d     = f3_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      rem_sh   = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, b_q};
      prod     = (sa_q ^ sb_q) ? -acc_q : acc_q;
      quo      = (sa_q ^ sb_q) ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
      rem      = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      if (!f3_q[2]) fix_res = (f3_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
      else          fix_res = f3_q[1] ? rem : quo;

      if (accept) begin
         f3_d  = bus.funct3;
         sa_d  = a_signed && bus.op_a[WIDTH-1];
         sb_d  = b_signed && bus.op_b[WIDTH-1];
         a_d   = {{WIDTH{1'b0}}, a_mag};
         b_d   = b_mag;
         acc_d = '0;
         cnt_d = '0;
         if (div_zero || div_ovf) res_d = special_res;
      end else if (state_q == S_CALC) begin
         cnt_d = cnt_q + CW'(1);
         if (!f3_q[2]) begin
            if (b_q[0]) acc_d = acc_q + a_q;
            a_d = a_q << 1;
            b_d = b_q >> 1;
         end else begin
            acc_d = {{(WIDTH-1){1'b0}}, (rem_diff[WIDTH] ? rem_sh : rem_diff)};
            a_d   = {{WIDTH{1'b0}}, a_q[WIDTH-2:0], ~rem_diff[WIDTH]};
         end
      end else if (state_q == S_FIX && !bus.kill) begin
         res_d = fix_res;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f3_q  <= '0;
         sa_q  <= 1'b0;
         sb_q  <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         res_q <= '0;
      end else begin
         f3_q  <= f3_d;
         sa_q  <= sa_d;
         sb_q  <= sb_d;
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         res_q <= res_d;
      end
   end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed scenarios plus randomized traffic, all checked
// every cycle against an arithmetic model of result value and done timing.
module tb_muldiv_sequencer;
   localparam int W   = 32;
   localparam int LAT = W + 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   muldiv_sequencer_if #(.WIDTH(W)) bus();
   muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;

   // model state: cycle index, outstanding op, the cycle its done must appear in
   int          cyc = 0;
   bit          pend = 1'b0;
   int          end_c = 0;
   bit          m_busy_now;
   logic [31:0] pres = '0;
   logic [31:0] m_res = '0;

   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] p;
      int          ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ia = int'(a);
      ib = int'(b);
      case (f)
         3'd0: begin p = 64'(sa * sb); return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(ia / ib);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(ia % ib);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && b == 0) return 1'b1;
      return (f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(7))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(15));
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         pend  = 1'b0;
         m_res = '0;
      end else begin
         m_busy_now = pend && cyc < end_c;
         if (bus.kill) begin
            if (m_busy_now) pend = 1'b0;
         end else if (bus.start && !m_busy_now) begin
            pend  = 1'b1;
            end_c = cyc + (is_special(bus.funct3, bus.op_a, bus.op_b) ? 1 : LAT);
            pres  = ref_op(bus.funct3, bus.op_a, bus.op_b);
         end
      end
      cyc++;
      if (pend && cyc == end_c) m_res = pres;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, output int s);
      @(posedge clk); #1;
      bus.start  = 1'b1;
      bus.funct3 = f;
      bus.op_a   = a;
      bus.op_b   = b;
      s = cyc;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int dcyc);
      dcyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            dcyc = cyc;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles (cycle %0d)", budget, cyc);
   endtask

   task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int s, d;
      issue(f, a, b, s);
      wait_done(60, d);
      if (d >= 0) chk({name, "_lat"}, 32'(d - s), 32'(exp_lat));
      chk({name, "_res"}, bus.result, exp_res);
   endtask

   initial begin
      int s, d, s2, nd;
      bus.start  = 1'b0;
      bus.kill   = 1'b0;
      bus.funct3 = '0;
      bus.op_a   = '0;
      bus.op_b   = '0;
      rst_n      = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
               chk("busy", 32'(bus.busy), 32'(pend && cyc < end_c));
               chk("done", 32'(bus.done), 32'(pend && cyc == end_c));
               chk("result", bus.result, m_res);
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #2;
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_result", bus.result, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      chk("pin_mul", ref_op(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
      chk("pin_mulhsu", ref_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
      chk("pin_div", ref_op(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      chk("pin_rem", ref_op(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
      chk("pin_rem_ovf", ref_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);

      run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
      repeat (3) @(negedge clk);
      chk("mul_hold", bus.result, 32'hFFFF_FFEB);

      // kill in cycle 10 of a divide
      issue(3'd5, 32'd100, 32'd7, s);
      repeat (9) @(posedge clk);
      #1 bus.kill = 1'b1;
      @(posedge clk); #1;
      bus.kill = 1'b0;
      @(negedge clk);
      chk("kill_busy", 32'(bus.busy), 32'h0);
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) nd++;
      end
      chk("kill_nodone", 32'(nd), 32'h0);
      chk("kill_result", bus.result, 32'hFFFF_FFEB);

      run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
      run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
      run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
      run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
      run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, 34);
      run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 34);
      run_op("divu_z", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("rem_z", 3'd6, 32'd5, 32'd0, 32'd5, 1);
      run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

      // start pulses while busy must be ignored
      issue(3'd0, 32'd3, 32'd5, s);
      repeat (4) @(posedge clk);
      #1;
      bus.start  = 1'b1;
      bus.funct3 = 3'd5;
      bus.op_a   = 32'd50;
      bus.op_b   = 32'd0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done(60, d);
      if (d >= 0) chk("ign_lat", 32'(d - s), 32'd34);
      chk("ign_res", bus.result, 32'd15);

      // kill wins over start from idle
      @(posedge clk); #1;
      bus.start  = 1'b1;
      bus.kill   = 1'b1;
      bus.funct3 = 3'd5;
      bus.op_a   = 32'd9;
      bus.op_b   = 32'd0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.kill  = 1'b0;
      @(negedge clk);
      chk("ks_busy", 32'(bus.busy), 32'h0);
      chk("ks_done", 32'(bus.done), 32'h0);
      chk("ks_result", bus.result, 32'd15);

      // back-to-back: new start issued inside the DONE cycle
      issue(3'd0, 32'd3, 32'd4, s);
      wait_done(60, d);
      chk("b2b_first", bus.result, 32'd12);
      bus.start  = 1'b1;
      bus.funct3 = 3'd5;
      bus.op_a   = 32'd9;
      bus.op_b   = 32'd3;
      s2 = cyc;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done(60, d);
      if (d >= 0) chk("b2b_lat", 32'(d - s2), 32'd34);
      chk("b2b_res", bus.result, 32'd3);

      // asynchronous reset in the middle of CALC
      issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, s);
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 32'h0);
      chk("arst_done", 32'(bus.done), 32'h0);
      chk("arst_result", bus.result, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 2500; i++) begin
         @(posedge clk); #1;
         bus.start  = ($urandom_range(99) < 20);
         bus.kill   = ($urandom_range(99) < 2);
         bus.funct3 = 3'($urandom_range(7));
         bus.op_a   = pick();
         bus.op_b   = pick();
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.kill  = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
